// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Op codes and FSM state encodings for the multiply/divide unit.
// Revision : 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_step
// Brief    : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision : 1.0
// ============================================================================
module mdu_step #(
    parameter int W = 32
) (
    input  logic           i_mode,      // 1 = divide, 0 = multiply
    input  logic [2*W-1:0] i_acc,
    input  logic [W-1:0]   i_operand,
    output logic [2*W-1:0] o_acc_next,
    output logic           o_q_bit
);

    logic [W:0]   w_sum;
    logic [W:0]   w_rem_sh;
    logic [W-1:0] w_diff;

    always_comb begin
        w_sum      = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_operand} : {(W+1){1'b0}});
        w_rem_sh   = i_acc[2*W-1:W-1];
        w_diff     = w_rem_sh[W-1:0] - i_operand;
        o_q_bit    = 1'b0;
        o_acc_next = {w_sum, i_acc[W-1:1]};
        if (i_mode) begin
            // Quotient bit is left as 0 here; the caller merges o_q_bit into bit 0.
            o_q_bit    = (w_rem_sh >= {1'b0, i_operand});
            o_acc_next = {(o_q_bit ? w_diff : w_rem_sh[W-1:0]), i_acc[W-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative MIPS multiply/divide unit with HI/LO registers.
// Revision : 1.0
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_A,
    input  logic [W-1:0] i_B,
    input  logic         i_flush,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_zero,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    mdu_state_t     r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_operand, r_hi, r_lo;
    logic           r_is_div, r_neg_q, r_neg_r, r_div_zero, r_done, r_dz_out;

    logic           w_md_op, w_signed, w_is_div, w_accept;
    logic           w_a_neg, w_b_neg, w_q_bit;
    logic [W-1:0]   w_a_abs, w_b_abs, w_quo, w_rem, w_hi_fix, w_lo_fix;
    logic [2*W-1:0] w_acc_next, w_prod;

    always_comb begin
        w_md_op  = 1'b0;
        w_signed = 1'b0;
        w_is_div = 1'b0;
        case (i_op)
            MDU_MULT:  begin w_md_op = 1'b1; w_signed = 1'b1; end
            MDU_MULTU: begin w_md_op = 1'b1; end
            MDU_DIV:   begin w_md_op = 1'b1; w_signed = 1'b1; w_is_div = 1'b1; end
            MDU_DIVU:  begin w_md_op = 1'b1; w_is_div = 1'b1; end
            default:   ;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && i_start && !i_flush;
    assign w_a_neg  = w_signed & i_A[W-1];
    assign w_b_neg  = w_signed & i_B[W-1];
    assign w_a_abs  = w_a_neg ? -i_A : i_A;
    assign w_b_abs  = w_b_neg ? -i_B : i_B;

    mdu_step #(.W(W)) u_step (
        .i_mode     (r_is_div),
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .o_acc_next (w_acc_next),
        .o_q_bit    (w_q_bit)
    );

    // Sign correction applied to the unsigned magnitude result in FIX.
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quo    = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem    = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    assign w_hi_fix = r_is_div ? w_rem : w_prod[2*W-1:W];
    assign w_lo_fix = r_is_div ? (r_div_zero ? {W{1'b1}} : w_quo) : w_prod[W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_md_op) w_state_next = ST_RUN;
            ST_RUN: begin
                if (i_flush)                         w_state_next = ST_IDLE;
                else if (r_cnt == CNT_W'(W-1))       w_state_next = ST_FIX;
            end
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_dz_out   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_md_op) begin
                        r_is_div   <= w_is_div;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= w_is_div && (i_B == '0);
                        r_cnt      <= '0;
                        r_acc      <= {{W{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
                        r_operand  <= w_is_div ? w_b_abs : w_a_abs;
                    end else if (w_accept && i_op == MDU_MTHI) begin
                        r_hi   <= i_A;
                        r_done <= 1'b1;
                    end else if (w_accept && i_op == MDU_MTLO) begin
                        r_lo   <= i_A;
                        r_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_flush) begin
                        r_acc <= w_acc_next | {{(2*W-1){1'b0}}, w_q_bit};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        r_hi     <= w_hi_fix;
                        r_lo     <= w_lo_fix;
                        r_done   <= 1'b1;
                        r_dz_out <= r_div_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_div_zero = r_dz_out;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule
`default_nettype wire
